// File: rtl/osc_count_writer.sv
// osc_count_writer: counts synchronized ring-oscillator edges, captures the
// count on each sample strobe into a 2-entry FIFO, and drains the FIFO into
// the readout SRAM over a req/gnt write port, one tagged word per sample.
module osc_count_writer #(
  parameter int NumOsc    = 10,
  parameter int CntWidth  = 24,
  parameter int AddrWidth = 8,
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [4:0]           osc_sel_i,
  input  logic                 sample_i,
  input  logic                 resetn_i,
  input  logic                 osc_edge_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic                 frame_done_o,
  output logic                 drop_o,
  output logic                 err_o
);

  localparam logic [5:0] NumOscW = 6'(NumOsc);
  localparam logic [4:0] LastOsc = 5'(NumOsc - 1);

  typedef logic [DataWidth-1:0] word_t;
  typedef enum logic {IDLE, REQ} state_e;

  // Edge counter with saturation flag
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                sat_q, sat_d;

  // Capture and FIFO control
  word_t       sample_word;
  logic        sel_ok, push, pop;
  word_t       fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  word_t       head;

  // Write side
  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic                 frame_done_q, frame_done_d;
  logic                 drop_q, err_q;

  // Next count: a clear wins over an edge; an edge at all-ones only sets sat.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (!resetn_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (osc_edge_i) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  // Edge counter registers
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign head = fifo_q[rd_ptr_q];

  // Capture word from the registered count, push/pop decisions, occupancy.
  always_comb begin
    sample_word                = '0;
    sample_word[31:27]         = osc_sel_i;
    sample_word[26]            = sat_q;
    sample_word[CntWidth-1:0]  = cnt_q;
    sel_ok  = ({1'b0, osc_sel_i} < NumOscW);
    pop     = (state_q == REQ) && mem_gnt_i;
    push    = sample_i && sel_ok && ((count_q != 2'd2) || pop);
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    frame_done_d = pop && (head[31:27] == LastOsc);
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    // NOTE: storage cells carry no reset; occupancy and pointers decide what is
    // valid, and the output data is gated while no request is pending.
    if (push) fifo_q[wr_ptr_q] <= sample_word;
  end

  // FIFO pointers, occupancy and sticky flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      if (sample_i && sel_ok && !push) drop_q <= 1'b1;
      if (sample_i && !sel_ok)         err_q  <= 1'b1;
    end
  end

  // Write FSM next state: request once the FIFO is seen non-empty, stay while
  // entries remain after a grant.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != 2'd0) state_d = REQ;
      REQ:     if (pop && (count_d == 2'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write FSM state, address counter and frame-done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
      if (pop) addr_q <= addr_q + 1'b1;
    end
  end

  assign mem_req_o    = (state_q == REQ);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = mem_req_o ? head : '0;
  assign frame_done_o = frame_done_q;
  assign drop_o       = drop_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_osc_count_writer.sv
// Bench for osc_count_writer: directed scenarios plus randomized traffic,
// scored against a queue-based reference model of the capture/write path.
module tb_osc_count_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  // Main instance (default parameters)
  logic [4:0]  osc_sel = '0;
  logic        sample = 1'b0, clr_n = 1'b1, edge_p = 1'b0, gnt = 1'b0;
  logic        req, frame_done, drop, err;
  logic [7:0]  addr;
  logic [31:0] wdata;

  // Small instance: 4-bit counter, 2-bit address
  logic [4:0]  s_sel = '0;
  logic        s_sample = 1'b0, s_clr_n = 1'b1, s_edge = 1'b0, s_gnt = 1'b1;
  logic        s_req, s_fd, s_drop, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  osc_count_writer dut (
    .clk(clk), .rstn(rstn), .osc_sel_i(osc_sel), .sample_i(sample),
    .resetn_i(clr_n), .osc_edge_i(edge_p), .mem_req_o(req), .mem_gnt_i(gnt),
    .mem_addr_o(addr), .mem_wdata_o(wdata), .frame_done_o(frame_done),
    .drop_o(drop), .err_o(err)
  );

  osc_count_writer #(.NumOsc(10), .CntWidth(4), .AddrWidth(2), .DataWidth(32)) dut_small (
    .clk(clk), .rstn(rstn), .osc_sel_i(s_sel), .sample_i(s_sample),
    .resetn_i(s_clr_n), .osc_edge_i(s_edge), .mem_req_o(s_req), .mem_gnt_i(s_gnt),
    .mem_addr_o(s_addr), .mem_wdata_o(s_wdata), .frame_done_o(s_fd),
    .drop_o(s_drop), .err_o(s_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: count value, queue of pending words, next address, flags.
  int unsigned  m_cnt;
  bit           m_sat;
  logic [31:0]  m_q[$];
  logic [7:0]   m_addr;
  bit           m_drop, m_err, m_fd;
  int           m_idle_run;
  int           fd_seen;
  int           writes_seen;

  function automatic logic [31:0] mk_word(input logic [4:0] sel, input bit sat, input int unsigned cnt);
    logic [23:0] c;
    c = cnt[23:0];
    return {sel, sat, 2'b00, c};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_sat = 0; m_q.delete(); m_addr = '0;
    m_drop = 0; m_err = 0; m_fd = 0; m_idle_run = 0;
  endtask

  // One cycle: drive inputs on the falling edge, compare the registered
  // outputs against the model, then advance the model across the next rise.
  task automatic step(input logic smp, input logic [4:0] sel, input logic cn,
                      input logic ed, input logic g);
    bit pop;
    @(negedge clk);
    sample = smp; osc_sel = sel; clr_n = cn; edge_p = ed; gnt = g;
    check("drop", {31'd0, drop}, {31'd0, m_drop});
    check("err", {31'd0, err}, {31'd0, m_err});
    check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    if (frame_done) fd_seen++;
    if (m_q.size() == 0) begin
      check("req_when_empty", {31'd0, req}, 32'd0);
      m_idle_run = 0;
    end else begin
      if (m_idle_run >= 1) check("req_rise", {31'd0, req}, 32'd1);
      if (req) begin
        check("addr", {24'd0, addr}, {24'd0, m_addr});
        check("wdata", wdata, m_q[0]);
        m_idle_run = 0;
      end else begin
        m_idle_run++;
      end
    end
    // Advance the model across the coming rising edge.
    pop  = req && g && (m_q.size() != 0);
    m_fd = 0;
    if (pop) begin
      writes_seen++;
      m_fd = (m_q[0][31:27] == 5'd9);
      void'(m_q.pop_front());
      m_addr = m_addr + 8'd1;
    end
    if (smp) begin
      if (sel >= 5'd10)          m_err = 1;
      else if (m_q.size() < 2)   m_q.push_back(mk_word(sel, m_sat, m_cnt));
      else                       m_drop = 1;
    end
    if (!cn) begin
      m_cnt = 0; m_sat = 0;
    end else if (ed) begin
      if (m_cnt == 32'h00FF_FFFF) m_sat = 1;
      else                        m_cnt++;
    end
  endtask

  task automatic s_cycle(input logic smp, input logic [4:0] sel, input logic cn, input logic ed);
    @(negedge clk);
    s_sample = smp; s_sel = sel; s_clr_n = cn; s_edge = ed;
  endtask

  task automatic s_wait_write(output logic [1:0] a, output logic [31:0] d, output logic ok);
    ok = 1'b0; a = '0; d = '0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      s_sample = 1'b0; s_edge = 1'b0; s_clr_n = 1'b1;
      if (s_req && s_gnt) begin
        a = s_addr; d = s_wdata; ok = 1'b1;
      end
    end
  endtask

  initial begin
    logic [1:0]  sa;
    logic [31:0] sd;
    logic        sok;
    int          fd_before, w_before;
    model_reset();
    fd_seen = 0;
    writes_seen = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_addr", {24'd0, addr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_flags", {29'd0, frame_done, drop, err}, 32'd0);
    rstn = 1'b1;

    // Five edges, capture osc 3, grant withheld for three cycles.
    repeat (5) step(0, 5'd0, 1, 1, 0);
    step(1, 5'd3, 1, 0, 0);
    step(0, 5'd0, 1, 0, 0);
    check("lat_t1_req", {31'd0, req}, 32'd0);
    step(0, 5'd0, 1, 0, 0);
    check("lat_t2_req", {31'd0, req}, 32'd1);
    check("lat_t2_wdata", wdata, 32'h1800_0005);
    check("lat_t2_addr", {24'd0, addr}, 32'd0);
    step(0, 5'd0, 1, 0, 0);
    step(0, 5'd0, 1, 0, 1);
    check("hold_wdata", wdata, 32'h1800_0005);
    w_before = writes_seen;
    step(0, 5'd0, 1, 0, 1);
    step(0, 5'd0, 1, 0, 1);
    check("single_write", writes_seen - w_before, 32'd0);
    check("single_write_req", {31'd0, req}, 32'd0);

    // Three samples with grant low: third dropped, then two back-to-back writes.
    step(1, 5'd0, 1, 0, 0);
    step(1, 5'd1, 1, 0, 0);
    step(1, 5'd2, 1, 0, 0);
    step(0, 5'd0, 1, 0, 0);
    check("drop_set", {31'd0, drop}, 32'd1);
    w_before = writes_seen;
    repeat (5) step(0, 5'd0, 1, 0, 1);
    check("drain_two", writes_seen - w_before, 32'd2);

    // Out-of-range selector: no write, err set, later samples still written.
    step(1, 5'd12, 1, 0, 1);
    step(0, 5'd0, 1, 0, 1);
    step(0, 5'd0, 1, 0, 1);
    check("err_set", {31'd0, err}, 32'd1);
    check("err_no_req", {31'd0, req}, 32'd0);

    // Two full sweeps with grant tied high; one frame_done per sweep.
    for (int s = 0; s < 2; s++) begin
      fd_before = fd_seen;
      for (int o = 0; o < 10; o++) step(1, 5'(o), 1, 1, 1);
      repeat (4) step(0, 5'd0, 1, 0, 1);
      check("sweep_fd_once", fd_seen - fd_before, 32'd1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic g;
      g = (i < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 3) == 0, 5'($urandom_range(0, 11)),
           $urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1, g);
    end
    repeat (4) step(0, 5'd0, 1, 0, 1);

    // rstn pulsed while a request is pending.
    step(1, 5'd4, 1, 0, 0);
    step(0, 5'd0, 1, 0, 0);
    step(0, 5'd0, 1, 0, 0);
    check("pre_rst_req", {31'd0, req}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_req_drop", {31'd0, req}, 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(1, 5'd6, 1, 0, 1);
    step(0, 5'd0, 1, 0, 1);
    step(0, 5'd0, 1, 0, 1);
    check("post_rst_addr", {24'd0, addr}, 32'd0);
    check("post_rst_flags", {30'd0, drop, err}, 32'd0);
    repeat (3) step(0, 5'd0, 1, 0, 1);

    // Small instance: saturation, clear, address wrap.
    repeat (20) s_cycle(0, 5'd0, 1, 1);
    s_cycle(1, 5'd0, 1, 0);
    s_wait_write(sa, sd, sok);
    check("s_sat_seen", {31'd0, sok}, 32'd1);
    check("s_sat_wdata", sd, 32'h0400_000F);
    check("s_sat_addr", {30'd0, sa}, 32'd0);
    s_cycle(0, 5'd0, 0, 0);
    s_cycle(0, 5'd0, 1, 1);
    s_cycle(0, 5'd0, 1, 1);
    s_cycle(1, 5'd0, 1, 0);
    s_wait_write(sa, sd, sok);
    check("s_clr_seen", {31'd0, sok}, 32'd1);
    check("s_clr_wdata", sd, 32'h0000_0002);
    check("s_clr_addr", {30'd0, sa}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      logic [1:0] ea;
      ea = 2'((2 + k) % 4);
      s_cycle(1, 5'(k), 1, 0);
      s_wait_write(sa, sd, sok);
      check("s_wrap_seen", {31'd0, sok}, 32'd1);
      check("s_wrap_addr", {30'd0, sa}, {30'd0, ea});
      check("s_wrap_wdata", sd, (32'(k) << 27) | 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/osc_count_writer.md
Name: osc_count_writer

Overview:
- Consumer end of the aging-sensor readout control interface: takes oscillator select, sample strobe and counter-clear from the readout counter controller.
- Counts synchronized ring-oscillator edges for the selected oscillator.
- On each sample strobe, captures the count and writes one tagged word per oscillator into the readout SRAM over a req/gnt write port.
- Sits between the oscillator edge synchronizer and the readout SRAM.

Parameters:
NumOsc, 10, number of oscillators per sweep; valid osc_sel_i range is 0..NumOsc-1; NumOsc <= 32
CntWidth, 24, edge counter width; must be <= 26
AddrWidth, 8, SRAM word address width
DataWidth, 32, SRAM word width; fixed at 32

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
osc_sel_i  input  5  oscillator index currently being measured
sample_i  input  1  one-cycle capture strobe
resetn_i  input  1  counter clear, active-low, synchronous in clk domain
osc_edge_i  input  1  one-cycle pulse per oscillator edge, already synchronized to clk
mem_req_o  output  1  SRAM write request
mem_gnt_i  input  1  SRAM write grant; a write completes on a cycle with req && gnt
mem_addr_o  output  AddrWidth  SRAM write address
mem_wdata_o  output  32  SRAM write data
frame_done_o  output  1  one-cycle pulse when the write for osc NumOsc-1 completes
drop_o  output  1  sticky: a sample was lost because the buffer was full
err_o  output  1  sticky: a sample arrived with osc_sel_i >= NumOsc

Behaviour:
- Async reset (rstn low): all state cleared.
  - All outputs 0; edge count 0; saturation flag 0; FIFO empty; address 0; FSM IDLE.
- Edge counter (CntWidth bits, plus a sat flag):
  - If resetn_i == 0: cnt <= 0 and sat <= 0. This has priority over any edge.
  - Else if osc_edge_i == 1 and cnt is all ones: cnt holds and sat <= 1.
  - Else if osc_edge_i == 1: cnt <= cnt + 1.
- Capture:
  - When sample_i == 1, the word is built from the registered cnt/sat of that same cycle. An edge or clear in the same cycle is not included.
  - Word layout: [31:27] osc_sel_i, [26] sat, [25:CntWidth] zero, [CntWidth-1:0] cnt.
  - If osc_sel_i >= NumOsc: no push, err_o <= 1.
- FIFO: 2 entries.
  - Push is accepted if occupancy < 2, or if a pop happens in the same cycle.
  - Otherwise the word is discarded and drop_o <= 1.
  - Sticky flags clear only on rstn.
- Write FSM, states IDLE and REQ:
  - IDLE -> REQ on the cycle after the FIFO becomes non-empty.
  - In REQ: mem_req_o = 1; mem_addr_o = address counter; mem_wdata_o = FIFO head. All three are held stable until grant.
  - On req && gnt: pop the head and increment the address.
  - After a grant: stay in REQ if another entry remains, so back-to-back writes run at 1 per cycle. Otherwise return to IDLE.
  - mem_req_o is 0 in IDLE.
- Latency: sample_i at cycle T with the FIFO empty and the FSM in IDLE:
  - entry visible at T+1;
  - mem_req_o high from T+2 with valid addr/wdata.
- Address counter:
  - AddrWidth bits; wraps from 2^AddrWidth-1 to 0 with no flag.
  - No reset between frames.
- frame_done_o: one-cycle pulse in the cycle after a grant whose word has osc_sel field == NumOsc-1.
- Simultaneous events:
  - sample_i with a grant while full: the pop frees a slot and the push is accepted.
  - sample_i with resetn_i == 0: captures the pre-clear count.
- rstn asserted mid-REQ: mem_req_o drops asynchronously and the pending word is lost.

Test Plan:
- resetn_i high, 5 osc_edge_i pulses, sample_i with osc_sel_i=3 at cycle T -> mem_req_o rises at T+2 with addr 0 and wdata 0x18000005. Hold gnt low 3 cycles: addr/wdata stay stable, then one write.
- CntWidth=4, 20 edges, sample with osc_sel_i=0 -> wdata[3:0]=0xF and bit26=1. Then resetn_i low 1 cycle, 2 edges, sample -> wdata=0x00000002.
- gnt held low, three samples (osc 0,1,2) -> third is dropped and drop_o=1. Then release gnt -> exactly two writes at addr 0,1 on consecutive cycles.
- Full sweep osc 0..9 with gnt tied high -> addresses 0..9 written in order; frame_done_o pulses once, one cycle after the osc 9 grant. A second sweep writes addresses 10..19.
- sample_i with osc_sel_i=12 -> no mem_req_o, err_o=1; subsequent valid samples are still written.
- rstn pulsed low while mem_req_o high -> mem_req_o=0 immediately. After release: FIFO empty, next write goes to addr 0, and drop_o/err_o are 0.
- AddrWidth=2, 5 samples -> writes to addresses 0,1,2,3,0.
